// File: rtl/martian_date_counter.sv
// Martian calendar keeper: year / month (0-23) / sol-of-month with one-sol tick,
// validated load, and a leap-residue (year mod 10) recomputed by repeated subtraction.
module martian_date_counter #(
  parameter int unsigned YEAR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [YEAR_W-1:0] load_year,
  input  logic [4:0]        load_month,
  input  logic [4:0]        load_day,
  input  logic              tick,
  output logic              ready,
  output logic [YEAR_W-1:0] year,
  output logic [4:0]        month,
  output logic [4:0]        day,
  output logic              leap,
  output logic              d27,
  output logic              d28,
  output logic              new_month,
  output logic              new_year,
  output logic              load_err
);

  typedef enum logic {S_RUN, S_INIT} state_t;

  localparam logic [YEAR_W-1:0] RES_ONE  = YEAR_W'(1);
  localparam logic [YEAR_W-1:0] RES_NINE = YEAR_W'(9);
  localparam logic [YEAR_W-1:0] RES_TEN  = YEAR_W'(10);

  state_t            r_state;
  logic [YEAR_W-1:0] r_year;
  logic [YEAR_W-1:0] r_residue;
  logic [4:0]        r_month;
  logic [4:0]        r_day;
  logic              r_new_month;
  logic              r_new_year;
  logic              r_load_err;

  logic              w_leap;
  logic              w_d28;
  logic [4:0]        w_month_len;
  logic              w_month_end;
  logic              w_year_max;
  logic              w_load_bad;

  // Residue stays below ten in RUN, so it doubles as year mod 10 for the leap rule.
  assign w_leap      = r_year[0] | (r_residue == '0);
  assign w_d28       = ~r_month[0] | ((r_month == 5'd23) & w_leap);
  assign w_month_len = w_d28 ? 5'd28 : 5'd27;
  assign w_month_end = (r_day >= w_month_len);
  assign w_year_max  = &r_year;

  // Month 23 with sol 28 is accepted here; it is corrected on INIT exit if the year is not leap.
  assign w_load_bad  = (load_month > 5'd23) | (load_day == 5'd0) | (load_day > 5'd28) |
                       ((load_day == 5'd28) & load_month[0] & (load_month != 5'd23));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_RUN;
      r_year      <= '0;
      r_residue   <= '0;
      r_month     <= '0;
      r_day       <= 5'd1;
      r_new_month <= 1'b0;
      r_new_year  <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_new_month <= 1'b0;
      r_new_year  <= 1'b0;
      if (load && !w_load_bad) begin
        r_state    <= S_INIT;
        r_year     <= load_year;
        r_residue  <= load_year;
        r_month    <= load_month;
        r_day      <= load_day;
        r_load_err <= 1'b0;
      end else begin
        r_load_err <= load;
        case (r_state)
          S_INIT: begin
            if (r_residue >= RES_TEN) begin
              r_residue <= r_residue - RES_TEN;
            end else begin
              r_state <= S_RUN;
              if ((r_month == 5'd23) && (r_day == 5'd28) && !w_leap) begin
                r_day      <= 5'd27;
                r_load_err <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (tick && !load) begin
              if (!w_month_end) begin
                r_day <= r_day + 5'd1;
              end else begin
                r_day       <= 5'd1;
                r_new_month <= 1'b1;
                if (r_month == 5'd23) begin
                  r_month    <= '0;
                  r_year     <= r_year + RES_ONE;
                  r_new_year <= 1'b1;
                  // Wrapping to year 0 must land on residue 0 regardless of the old residue.
                  if (w_year_max || (r_residue == RES_NINE))
                    r_residue <= '0;
                  else
                    r_residue <= r_residue + RES_ONE;
                end else begin
                  r_month <= r_month + 5'd1;
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign ready     = (r_state == S_RUN);
  assign year      = r_year;
  assign month     = r_month;
  assign day       = r_day;
  assign leap      = w_leap;
  assign d28       = w_d28;
  assign d27       = ~w_d28;
  assign new_month = r_new_month;
  assign new_year  = r_new_year;
  assign load_err  = r_load_err;

endmodule
